rand_arbiter: RTL and testbench
===============================

# rand_arbiter

Shares one 16-bit Fibonacci LFSR random source among NREQ requesters so that every granted requester receives a distinct word of the sequence. It owns the LFSR state, a reseed/warm-up sequencer and a round-robin arbiter, and it sits between the random source and the consumers that need random values (traffic shapers, test stimulus, backoff timers).

## Interface
- NREQ, 4: number of requesters, 2..16.
- WARM_CYC, 16: LFSR steps discarded after reset or reseed, 1..255.
- IDW, $clog2(NREQ): width of gnt_id.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_we  in  1  load seed into LFSR, restart warm-up.
- seed  in  16  seed value, sampled when seed_we=1.
- req  in  NREQ  level request, one bit per requester.
- gnt  out  NREQ  one-hot grant, combinational from registered state and req.
- gnt_id  out  IDW  index of the granted requester, valid when |gnt.
- rnd_out  out  16  random word delivered with gnt (current LFSR state).
- busy  out  1  1 while in WARM (no grants possible).

## Operation
- LFSR polynomial: taps 16,14,13,11; next = {s[14:0], s[15]^s[13]^s[12]^s[10]}. The state is never 0.
- FSM states:
  - WARM: LFSR steps every cycle; warm counter increments; gnt=0.
    - WARM -> RUN on the edge where the counter reaches WARM_CYC-1, i.e. after exactly WARM_CYC steps.
  - RUN: grants are issued.
    - RUN -> WARM on seed_we.
  - seed_we in any state: LFSR <= (seed==0 ? 16'h0001 : seed), counter <= 0, state <= WARM.
- Arbitration in RUN, when seed_we=0 and req!=0:
  - Winner is the first set req bit scanning from ptr+1 upward, wrapping mod NREQ.
  - gnt[winner]=1, gnt_id=winner, rnd_out = current LFSR.
  - At the edge: LFSR steps, ptr <= winner.
- No grant means no LFSR step in RUN. The sequence advances exactly once per delivered word.
- Handshake: the requester samples rnd_out in the cycle its gnt bit is high. A held req is a new request each cycle, so one requester alone receives one word per cycle.
- Reset values:
  - LFSR = 16'h0001; state = WARM; counter = 0; ptr = NREQ-1 (requester 0 has first priority).
  - gnt = 0, gnt_id = 0, busy = 1, rnd_out = 16'h0001.

## Timing
- Warm-up: after rst deasserts, edges E1..E_WARM_CYC step the LFSR. The first possible grant is in the cycle after E_WARM_CYC.
  - With WARM_CYC=16 from 0x0001, that first grant carries 0x002D.
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when the block is in RUN.
- Throughput: 1 word per cycle total, shared round-robin. With all NREQ requesting, each requester is granted once every NREQ cycles.
- seed_we has priority over req in the same cycle: no grant, no step. busy=1 from the next cycle for WARM_CYC cycles.
- rst mid-operation immediately forces all reset values, including gnt=0 during rst. Any word shown in that cycle is not delivered.
- ptr changes only on a grant. A req bit dropping in the same cycle it would be granted results in no grant to that requester.

## Test plan
- Reset, WARM_CYC=16, req=0001 held -> busy=1 for 16 cycles, then gnt=0001 each cycle with rnd_out 0x002D, 0x005A, 0x00B4.
- After warm-up, req=1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; gnt_id 0,1,2,3,0,1,2,3; 8 consecutive distinct LFSR words.
- req=0101 after a grant to requester 0 -> next grant goes to requester 2, then 0; requesters 1 and 3 are never granted.
- seed_we=1 with seed=0 while req=1111 in RUN -> gnt=0 that cycle, busy=1 for 16 cycles, then sequence resumes from 0x002D (seed forced to 0x0001).
- seed=0xACE1 loaded, 16 warm steps, then 65535 single-requester grants -> no word repeats and the 65536th word equals the first (maximal period).
- rst asserted for 1 cycle mid-RUN with req=1111 -> gnt=0 immediately, busy=1, and after release the first grant goes to requester 0 with 0x002D.

Source files
------------

// File: rtl/rand_arbiter.sv
// rand_arbiter: one 16-bit Fibonacci LFSR shared round-robin among NREQ
// requesters, with seed reload and a warm-up phase before grants start.
module rand_arbiter #(
  parameter int NREQ     = 4,
  parameter int WARM_CYC = 16,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_we,
  input  logic [15:0]     seed,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic [15:0]     rnd_out,
  output logic            busy
);

  typedef enum logic {WARM, RUN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  win;
  logic            found;
  logic            grant_en;
  logic [15:0]     lfsr_nx;
  int unsigned     idx;

  assign lfsr_nx = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Scan from ptr+1 upward, wrapping, so the last winner has lowest priority
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign grant_en = (state_q == RUN) && !seed_we && found;
  assign gnt      = grant_en ? (NREQ'(1) << win) : '0;
  assign gnt_id   = grant_en ? win : '0;
  assign rnd_out  = lfsr_q;
  assign busy     = (state_q == WARM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    if (seed_we) begin
      lfsr_d  = (seed == 16'h0000) ? 16'h0001 : seed;
      cnt_d   = '0;
      state_d = WARM;
    end else begin
      unique case (state_q)
        WARM: begin
          lfsr_d = lfsr_nx;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'(WARM_CYC - 1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (found) begin
            lfsr_d = lfsr_nx;
            ptr_d  = win;
          end
        end
        default: state_d = WARM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WARM;
      cnt_q   <= '0;
      lfsr_q  <= 16'h0001;
      ptr_q   <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter: directed stimulus with a queued scoreboard; a monitor
// compares every expected cycle, plus a full-period uniqueness sweep.
module tb_rand_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_we = 1'b0;
  logic [15:0] seed = '0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [15:0] rnd_out;
  logic        busy;

  rand_arbiter #(.NREQ(4), .WARM_CYC(16)) dut (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed),
    .req(req), .gnt(gnt), .gnt_id(gnt_id),
    .rnd_out(rnd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  g;
    logic [1:0]  id;
    logic [15:0] r;
    logic        b;
    bit          per;
  } exp_t;

  exp_t        q[$];
  int          vecs = 0;
  int          errs = 0;
  logic [15:0] m;
  bit          seen[int];
  int          pc = 0;
  int          rep = 0;
  logic [15:0] first_w, last_w;

  function automatic logic [15:0] nx(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [1:0] oh2id(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic drive(input logic r, input logic [3:0] rq,
                       input logic we, input logic [15:0] sd,
                       input logic [3:0] eg, input logic eb,
                       input int er, input bit per = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req = rq; seed_we = we; seed = sd;
    if (r) m = 16'h0001;
    e.g   = eg;
    e.id  = oh2id(eg);
    e.b   = eb;
    e.r   = (er < 0) ? m : er[15:0];
    e.per = per;
    q.push_back(e);
    if (r) m = 16'h0001;
    else if (we) m = (sd == 16'h0000) ? 16'h0001 : sd;
    else if (eb || eg != 4'b0) m = nx(m);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vecs++;
      if (gnt !== e.g || gnt_id !== e.id ||
          rnd_out !== e.r || busy !== e.b) begin
        errs++;
        $display("FAIL cyc%0d: gnt=%b id=%0d rnd=%h busy=%b, want gnt=%b id=%0d rnd=%h busy=%b",
                 vecs, gnt, gnt_id, rnd_out, busy, e.g, e.id, e.r, e.b);
      end
      if (e.per) begin
        if (pc == 0) first_w = rnd_out;
        if (pc < 65535) begin
          if (seen.exists(int'(rnd_out))) rep++;
          seen[int'(rnd_out)] = 1'b1;
        end else begin
          last_w = rnd_out;
        end
        pc++;
      end
    end
  end

  initial begin
    m = 16'h0001;
    drive(1, 4'b0001, 0, 0, 4'b0000, 1, 16'h0001);
    drive(1, 4'b0001, 0, 0, 4'b0000, 1, 16'h0001);
    repeat (16) drive(0, 4'b0001, 0, 0, 4'b0000, 1, -1);
    drive(0, 4'b0001, 0, 0, 4'b0001, 0, 16'h002D);
    drive(0, 4'b0001, 0, 0, 4'b0001, 0, 16'h005A);
    drive(0, 4'b0001, 0, 0, 4'b0001, 0, 16'h00B4);
    drive(0, 4'b0101, 0, 0, 4'b0100, 0, -1);
    drive(0, 4'b0101, 0, 0, 4'b0001, 0, -1);
    drive(0, 4'b0101, 0, 0, 4'b0100, 0, -1);
    drive(0, 4'b0101, 0, 0, 4'b0001, 0, -1);
    drive(0, 4'b1111, 1, 16'h0000, 4'b0000, 0, -1);
    repeat (16) drive(0, 4'b1111, 0, 0, 4'b0000, 1, -1);
    drive(0, 4'b1111, 0, 0, 4'b0010, 0, 16'h002D);
    drive(0, 4'b1111, 0, 0, 4'b0100, 0, 16'h005A);
    drive(1, 4'b1111, 0, 0, 4'b0000, 1, 16'h0001);
    repeat (16) drive(0, 4'b1111, 0, 0, 4'b0000, 1, -1);
    drive(0, 4'b1111, 0, 0, 4'b0001, 0, 16'h002D);
    for (int i = 1; i < 8; i++)
      drive(0, 4'b1111, 0, 0, 4'(1 << (i % 4)), 0, -1);
    drive(0, 4'b0001, 1, 16'hACE1, 4'b0000, 0, -1);
    repeat (16) drive(0, 4'b0001, 0, 0, 4'b0000, 1, -1);
    for (int i = 0; i < 65536; i++)
      drive(0, 4'b0001, 0, 0, 4'b0001, 0, -1, 1'b1);
    @(posedge clk);
    #1;
    req = '0;
    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    @(posedge clk);
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    vecs++;
    if (pc != 65536) begin
      errs++;
      $display("FAIL period_count: got %0d grants, want 65536", pc);
    end
    vecs++;
    if (rep != 0) begin
      errs++;
      $display("FAIL period_repeat: got %0d repeats, want 0", rep);
    end
    vecs++;
    if (last_w !== first_w) begin
      errs++;
      $display("FAIL period_wrap: word65536=%h, want %h", last_w, first_w);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
